// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH independent programmable clock dividers running off
// master_clk. Each channel produces a 50%-duty square wave and a one-cycle
// strobe on every toggle. Divisors are writable at runtime, and a common
// sync pulse re-phases every channel at once.
module clk_div_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 28,
  parameter int DIV_RESET = 100000,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic              master_clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [CNT_W-1:0]  ctr_p0 [NUM_CH];
  logic [CNT_W-1:0]  div_p0 [NUM_CH];
  logic [NUM_CH-1:0] wr_hit;

  // Decode the write strobe to a per-channel hit; an index with no
  // matching channel produces no hit, so the write is dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_en && (wr_ch == CH_W'(i))) wr_hit[i] = 1'b1;
    end
  end

  // Per-channel counter, divisor, square wave and toggle strobe.
  // Priority: reset, then sync / write restart, then normal counting.
  // A divisor write always clears its counter, so ctr never sits above div
  // and an equality compare is sufficient.
  always_ff @(posedge master_clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ctr_p0[i] <= '0;
        div_p0[i] <= CNT_W'(DIV_RESET);
      end
      clk_out <= '0;
      tick    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) div_p0[i] <= wr_div;
        if (sync || wr_hit[i]) begin
          ctr_p0[i]  <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (ch_en[i]) begin
          if (ctr_p0[i] == div_p0[i]) begin
            ctr_p0[i]  <= '0;
            clk_out[i] <= ~clk_out[i];
            tick[i]    <= 1'b1;
          end else begin
            ctr_p0[i]  <= ctr_p0[i] + CNT_W'(1);
            tick[i]    <= 1'b0;
          end
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed and randomized stimulus for clk_div_bank,
// compared every cycle against a count-based reference model.
module tb_clk_div_bank;

  localparam int NUM_CH    = 3;
  localparam int CNT_W     = 12;
  localparam int DIV_RESET = 1000;
  localparam int CH_W      = $clog2(NUM_CH);

  logic              master_clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              sync = 1'b0;
  logic              wr_en = 1'b0;
  logic [CH_W-1:0]   wr_ch = '0;
  logic [CNT_W-1:0]  wr_div = '0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  int total = 0;
  int bad   = 0;

  // Reference model: enabled cycles elapsed since the last restart
  longint run_n   [NUM_CH];
  longint m_div   [NUM_CH];
  bit     en_last [NUM_CH];

  clk_div_bank #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DIV_RESET(DIV_RESET)
  ) dut (
    .master_clk(master_clk),
    .rst       (rst),
    .ch_en     (ch_en),
    .sync      (sync),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_div    (wr_div),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 master_clk = ~master_clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at that edge,
  // then compare every channel's outputs.
  task automatic step();
    @(posedge master_clk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        run_n[c] = 0; m_div[c] = DIV_RESET; en_last[c] = 0;
      end else begin
        bit wrote;
        wrote = wr_en && (int'(wr_ch) == c);
        if (wrote) m_div[c] = longint'(wr_div);
        if (sync || wrote) begin
          run_n[c] = 0; en_last[c] = 0;
        end else if (ch_en[c]) begin
          run_n[c]++; en_last[c] = 1;
        end else begin
          en_last[c] = 0;
        end
      end
    end
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      longint hp;
      hp = m_div[c] + 1;
      chk($sformatf("clk_out%0d", c), longint'(clk_out[c]), (run_n[c] / hp) % 2);
      chk($sformatf("tick%0d", c), longint'(tick[c]),
          (en_last[c] && (run_n[c] % hp == 0)) ? 1 : 0);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write_div(input int ch, input int d);
    wr_en = 1'b1; wr_ch = CH_W'(ch); wr_div = CNT_W'(d);
    step();
    wr_en = 1'b0;
  endtask

  // Count edges after reset release until ch0 first ticks (bounded).
  task automatic first_tick_check(input string tag);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 2 * DIV_RESET + 10; k++) begin
      step();
      cnt++;
      if (tick[0]) break;
    end
    chk(tag, cnt, DIV_RESET + 1);
    chk({tag, "_clk"}, longint'(clk_out[0]), 1);
    step();
    chk({tag, "_width"}, longint'(tick[0]), 0);
  endtask

  initial begin
    // Reset for three cycles, all channels enabled
    rst = 1'b1; ch_en = '1;
    run(3);
    chk("rst_clk_out", longint'(clk_out), 0);
    chk("rst_tick", longint'(tick), 0);
    #1 rst = 1'b0;
    first_tick_check("first_tick");

    // ch1 divisor 2: period 6, tick every 3
    write_div(1, 2);
    run(30);

    // ch2 divisor 0, then rewrite on a terminal-count cycle
    write_div(2, 0);
    run(10);
    write_div(2, 5);
    chk("wr_tc_tick2", longint'(tick[2]), 0);
    run(15);

    // Freeze ch1 mid-count for 10 cycles, then resume
    run(1);
    ch_en[1] = 1'b0;
    run(10);
    ch_en[1] = 1'b1;
    run(20);

    // ch0 at 4, ch1 at 2, then sync and an out-of-range write
    write_div(0, 4);
    run(7);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_clk_out", longint'(clk_out), 0);
    run(3);
    chk("sync_ch1_tog", longint'(clk_out[1]), 1);
    run(2);
    chk("sync_ch0_tog", longint'(clk_out[0]), 1);
    wr_en = 1'b1; wr_ch = CH_W'(NUM_CH); wr_div = CNT_W'(1);
    step();
    wr_en = 1'b0;
    run(12);

    // Maximum divisor on ch2: wraps cleanly after 2^CNT_W cycles
    write_div(2, (1 << CNT_W) - 1);
    run(2 * (1 << CNT_W) + 5);

    // Randomized enables, writes and syncs
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NUM_CH; c++) ch_en[c] = ($urandom_range(0, 7) != 0);
      wr_en  = ($urandom_range(0, 15) == 0);
      wr_ch  = CH_W'($urandom_range(0, (1 << CH_W) - 1));
      wr_div = CNT_W'($urandom_range(0, 6));
      sync   = ($urandom_range(0, 63) == 0);
      step();
    end
    wr_en = 1'b0; sync = 1'b0; ch_en = '1;

    // Reset mid-count with sync and write active
    rst = 1'b1; sync = 1'b1; wr_en = 1'b1; wr_ch = '0; wr_div = CNT_W'(3);
    step();
    chk("rst2_clk_out", longint'(clk_out), 0);
    chk("rst2_tick", longint'(tick), 0);
    sync = 1'b0; wr_en = 1'b0;
    run(2);
    rst = 1'b0;
    first_tick_check("rst2_first_tick");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
